// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared constants, state encoding and helpers for the ALU issue scheduler
package alu_sched_pkg;

    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_NOP      = 7'h00;
    localparam logic       MODE_SPLIT   = 1'b0;
    localparam logic       MODE_UNIFIED = 1'b1;

    typedef enum logic [1:0] {
        SPLIT   = 2'd0,
        UNIFIED = 2'd1,
        SWITCH  = 2'd2
    } sched_state_t;

    function automatic logic is_branch(input logic [6:0] opc);
        return opc == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/alu_issue_scheduler_rr_arb2.sv
// rtl/alu_issue_scheduler_rr_arb2.sv - 2-way round-robin pointer and winner select (module rr_arb2)
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    input  logic load,
    input  logic load_val,
    output logic ptr,
    output logic grant
);

    // A sole requester wins outright; on contention the pointer decides.
    assign grant = (req_a & ~req_b) ? 1'b0 :
                   (req_b & ~req_a) ? 1'b1 : ptr;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (load)
            ptr <= load_val;
        else if (advance)
            ptr <= ~ptr;
    end

endmodule

// File: rtl/alu_issue_scheduler.sv
// rtl/alu_issue_scheduler.sv - dual-lane split/unified ALU issue scheduler; ALU_SCHED_PERF_EN adds perf counters
module alu_issue_scheduler
    import alu_sched_pkg::*;
#(
    parameter int SWITCH_CYCLES = 1
`ifdef ALU_SCHED_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic       a_wide,
    input  logic [6:0] a_opcode,
    input  logic [2:0] a_funct3,
    input  logic [6:0] a_funct7,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic       b_wide,
    input  logic [6:0] b_opcode,
    input  logic [2:0] b_funct3,
    input  logic [6:0] b_funct7,
    output logic       iss_valid_a,
    output logic       iss_valid_b,
    output logic [6:0] opcodeA,
    output logic [6:0] opcodeB,
    output logic [2:0] funct3A,
    output logic [2:0] funct3B,
    output logic [6:0] funct7A,
    output logic [6:0] funct7B,
    output logic       mode,
    output logic       iss_lane
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_issued,
    output logic [PERF_W-1:0] perf_bubbles,
    output logic [PERF_W-1:0] perf_switch
`endif
);

    localparam logic [2:0] SW_LAST = 3'(SWITCH_CYCLES - 1);

    sched_state_t state;
    logic         target;
    logic [2:0]   sw_cnt;

    logic rr_ptr, win, win_wide, any_valid, both_valid;
    logic take_a, take_b, rr_adv, rr_load, rr_val, go_switch, sw_target, uni_issue;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .advance (rr_adv),
        .load    (rr_load),
        .load_val(rr_val),
        .ptr     (rr_ptr),
        .grant   (win)
    );

    assign any_valid  = a_valid | b_valid;
    assign both_valid = a_valid & b_valid;
    assign win_wide   = win ? b_wide : a_wide;

    always_comb begin
        take_a    = 1'b0;
        take_b    = 1'b0;
        rr_adv    = 1'b0;
        rr_load   = 1'b0;
        rr_val    = 1'b0;
        go_switch = 1'b0;
        sw_target = MODE_SPLIT;
        case (state)
            SPLIT: begin
                if (both_valid && !a_wide && !b_wide) begin
                    // Two branches cannot share the ALU; alternate them.
                    if (is_branch(a_opcode) && is_branch(b_opcode)) begin
                        take_a = ~rr_ptr;
                        take_b = rr_ptr;
                        rr_adv = 1'b1;
                    end else begin
                        take_a = 1'b1;
                        take_b = 1'b1;
                    end
                end else if (both_valid && (a_wide ^ b_wide)) begin
                    take_a  = ~a_wide;
                    take_b  = ~b_wide;
                    rr_load = 1'b1;
                    rr_val  = b_wide;
                end else if (any_valid) begin
                    if (win_wide) begin
                        go_switch = 1'b1;
                        sw_target = MODE_UNIFIED;
                    end else begin
                        take_a = ~win;
                        take_b = win;
                    end
                end
            end
            UNIFIED: begin
                if (any_valid) begin
                    if (win_wide) begin
                        take_a = ~win;
                        take_b = win;
                        rr_adv = both_valid;
                    end else begin
                        go_switch = 1'b1;
                        sw_target = MODE_SPLIT;
                    end
                end
            end
            default: ;
        endcase
    end

    assign a_ready   = take_a & ~rst;
    assign b_ready   = take_b & ~rst;
    assign uni_issue = (state == UNIFIED) & (take_a | take_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SPLIT;
            mode        <= MODE_SPLIT;
            target      <= MODE_SPLIT;
            sw_cnt      <= 3'd0;
            iss_valid_a <= 1'b0;
            iss_valid_b <= 1'b0;
            opcodeA     <= OPC_NOP;
            opcodeB     <= OPC_NOP;
            funct3A     <= 3'd0;
            funct3B     <= 3'd0;
            funct7A     <= 7'd0;
            funct7B     <= 7'd0;
            iss_lane    <= 1'b0;
        end else begin
            case (state)
                SWITCH: begin
                    if (sw_cnt == SW_LAST) begin
                        state  <= (target == MODE_UNIFIED) ? UNIFIED : SPLIT;
                        sw_cnt <= 3'd0;
                    end else begin
                        sw_cnt <= sw_cnt + 3'd1;
                    end
                end
                default: begin
                    if (go_switch) begin
                        state  <= SWITCH;
                        mode   <= sw_target;
                        target <= sw_target;
                        sw_cnt <= 3'd0;
                    end
                end
            endcase

            // Issue registers reload every cycle so an empty slot reads as zero.
            if (uni_issue) begin
                iss_valid_a <= 1'b1;
                iss_valid_b <= 1'b0;
                opcodeA     <= win ? b_opcode : a_opcode;
                funct3A     <= win ? b_funct3 : a_funct3;
                funct7A     <= win ? b_funct7 : a_funct7;
                opcodeB     <= OPC_NOP;
                funct3B     <= 3'd0;
                funct7B     <= 7'd0;
                iss_lane    <= win;
            end else begin
                iss_valid_a <= take_a;
                iss_valid_b <= take_b;
                opcodeA     <= take_a ? a_opcode : OPC_NOP;
                funct3A     <= take_a ? a_funct3 : 3'd0;
                funct7A     <= take_a ? a_funct7 : 7'd0;
                opcodeB     <= take_b ? b_opcode : OPC_NOP;
                funct3B     <= take_b ? b_funct3 : 3'd0;
                funct7B     <= take_b ? b_funct7 : 7'd0;
                iss_lane    <= 1'b0;
            end
        end
    end

`ifdef ALU_SCHED_PERF_EN
    function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] c, input logic [1:0] n);
        logic [PERF_W:0] s;
        s = {1'b0, c} + {{(PERF_W-1){1'b0}}, n};
        return s[PERF_W] ? {PERF_W{1'b1}} : s[PERF_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued  <= '0;
            perf_bubbles <= '0;
            perf_switch  <= '0;
        end else begin
            perf_issued  <= sat_add(perf_issued, {1'b0, take_a} + {1'b0, take_b});
            perf_bubbles <= sat_add(perf_bubbles, {1'b0, state == SWITCH});
            perf_switch  <= sat_add(perf_switch, {1'b0, go_switch});
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb/tb_alu_issue_scheduler.sv - scoreboard bench for alu_issue_scheduler (perf checks under ALU_SCHED_PERF_EN)
module tb_alu_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_ready, a_wide, b_valid, b_ready, b_wide;
    logic [6:0] a_opcode, a_funct7, b_opcode, b_funct7;
    logic [2:0] a_funct3, b_funct3;
    logic       iss_valid_a, iss_valid_b, mode, iss_lane;
    logic [6:0] opcodeA, opcodeB, funct7A, funct7B;
    logic [2:0] funct3A, funct3B;
`ifdef ALU_SCHED_PERF_EN
    logic [31:0] perf_issued, perf_bubbles, perf_switch;
`endif

    alu_issue_scheduler dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_wide(a_wide),
        .a_opcode(a_opcode), .a_funct3(a_funct3), .a_funct7(a_funct7),
        .b_valid(b_valid), .b_ready(b_ready), .b_wide(b_wide),
        .b_opcode(b_opcode), .b_funct3(b_funct3), .b_funct7(b_funct7),
        .iss_valid_a(iss_valid_a), .iss_valid_b(iss_valid_b),
        .opcodeA(opcodeA), .opcodeB(opcodeB), .funct3A(funct3A), .funct3B(funct3B),
        .funct7A(funct7A), .funct7B(funct7B), .mode(mode), .iss_lane(iss_lane)
`ifdef ALU_SCHED_PERF_EN
        , .perf_issued(perf_issued), .perf_bubbles(perf_bubbles), .perf_switch(perf_switch)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       va;
        logic       vb;
        logic [6:0] opa;
        logic [2:0] f3a;
        logic [6:0] f7a;
        logic [6:0] opb;
        logic [2:0] f3b;
        logic [6:0] f7b;
        logic       md;
        logic       lane;
    } iss_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_RW = 7'b0111011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] F7_SUB = 7'b0100000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    iss_t exp_q[$];
    iss_t got, want;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (iss_valid_a || iss_valid_b) begin
            got = {iss_valid_a, iss_valid_b, opcodeA, funct3A, funct7A,
                   opcodeB, funct3B, funct7B, mode, iss_lane};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual=%0h required=none", got);
            end else begin
                want = exp_q.pop_front();
                chk("issue", 64'(got), 64'(want));
            end
        end
    end

    task automatic drv(input logic av, input logic aw, input logic [6:0] aop, input logic [2:0] af3,
                       input logic [6:0] af7, input logic bv, input logic bw, input logic [6:0] bop,
                       input logic [2:0] bf3, input logic [6:0] bf7);
        a_valid = av; a_wide = aw; a_opcode = aop; a_funct3 = af3; a_funct7 = af7;
        b_valid = bv; b_wide = bw; b_opcode = bop; b_funct3 = bf3; b_funct7 = bf7;
    endtask

    task automatic idle();
        drv(0, 0, 7'd0, 3'd0, 7'd0, 0, 0, 7'd0, 3'd0, 7'd0);
    endtask

    task automatic pu(input logic va, input logic vb, input logic [6:0] opa, input logic [2:0] f3a,
                      input logic [6:0] f7a, input logic [6:0] opb, input logic [2:0] f3b,
                      input logic [6:0] f7b, input logic md, input logic lane);
        exp_q.push_back({va, vb, opa, f3a, f7a, opb, f3b, f7b, md, lane});
    endtask

    task automatic step(input string tag, input logic era, input logic erb, input logic em);
        #3;
        chk({tag, "_a_ready"}, 64'(a_ready), 64'(era));
        chk({tag, "_b_ready"}, 64'(b_ready), 64'(erb));
        chk({tag, "_mode"}, 64'(mode), 64'(em));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk(tag, 64'({iss_valid_a, iss_valid_b, opcodeA, funct3A, funct7A, opcodeB,
                      funct3B, funct7B, mode, iss_lane}), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        drv(1, 0, OP_R, 3'd0, 7'd0, 1, 0, OP_R, 3'd0, F7_SUB);
        step("rst", 0, 0, 0);
        chk_cleared("rst_outputs");
        rst = 1'b0;

        // add on A, sub on B, both narrow
        drv(1, 0, OP_R, 3'd0, 7'd0, 1, 0, OP_R, 3'd0, F7_SUB);
        pu(1, 1, OP_R, 3'd0, 7'd0, OP_R, 3'd0, F7_SUB, 0, 0);
        step("t1", 1, 1, 0);
        idle();
        step("t1_idle", 0, 0, 0);

        // wide op on A forces a switch to unified
        drv(1, 1, OP_R, 3'd0, F7_MUL, 0, 0, 7'd0, 3'd0, 7'd0);
        step("t2_c0", 0, 0, 0);
        step("t2_c1", 0, 0, 1);
        pu(1, 0, OP_R, 3'd0, F7_MUL, 7'd0, 3'd0, 7'd0, 1, 0);
        step("t2_c2", 1, 0, 1);
        idle();
        for (int i = 0; i < 3; i++) step("t2_idle", 0, 0, 1);
`ifdef ALU_SCHED_PERF_EN
        chk("perf_switch", 64'(perf_switch), 64'd1);
        chk("perf_bubbles", 64'(perf_bubbles), 64'd1);
        chk("perf_issued", 64'(perf_issued), 64'd3);
`endif

        // both lanes wide in unified: strict alternation
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, OP_R, 3'((i + 1) / 2), F7_MUL, 1, 1, OP_RW, 3'(4 + i / 2), F7_MUL);
            if (i % 2 == 0)
                pu(1, 0, OP_R, 3'((i + 1) / 2), F7_MUL, 7'd0, 3'd0, 7'd0, 1, 0);
            else
                pu(1, 0, OP_RW, 3'(4 + i / 2), F7_MUL, 7'd0, 3'd0, 7'd0, 1, 1);
            step("t3", (i % 2 == 0), (i % 2 == 1), 1);
        end

        // two branches: switch back to split, then one per cycle
        drv(1, 0, OP_BR, 3'd0, 7'd0, 1, 0, OP_BR, 3'd1, 7'd0);
        step("t4_uni", 0, 0, 1);
        step("t4_sw", 0, 0, 0);
        pu(1, 0, OP_BR, 3'd0, 7'd0, 7'd0, 3'd0, 7'd0, 0, 0);
        step("t4_c1", 1, 0, 0);
        drv(1, 0, OP_BR, 3'd4, 7'd0, 1, 0, OP_BR, 3'd1, 7'd0);
        pu(0, 1, 7'd0, 3'd0, 7'd0, OP_BR, 3'd1, 7'd0, 0, 0);
        step("t4_c2", 0, 1, 0);
        drv(1, 0, OP_BR, 3'd4, 7'd0, 0, 0, 7'd0, 3'd0, 7'd0);
        pu(1, 0, OP_BR, 3'd4, 7'd0, 7'd0, 3'd0, 7'd0, 0, 0);
        step("t4_c3", 1, 0, 0);

        // narrow A next to wide B: A goes alone, then B triggers a switch
        drv(1, 0, OP_R, 3'd0, 7'd0, 1, 1, OP_R, 3'd0, F7_MUL);
        pu(1, 0, OP_R, 3'd0, 7'd0, 7'd0, 3'd0, 7'd0, 0, 0);
        step("mix", 1, 0, 0);
        drv(0, 0, 7'd0, 3'd0, 7'd0, 1, 1, OP_R, 3'd0, F7_MUL);
        step("mix_sw", 0, 0, 0);

        // reset while in SWITCH
        rst = 1'b1;
        step("t5_rst", 0, 0, 1);
        chk_cleared("t5_outputs");
        rst = 1'b0;
        drv(0, 0, 7'd0, 3'd0, 7'd0, 1, 0, OP_R, 3'd0, F7_SUB);
        pu(0, 1, 7'd0, 3'd0, 7'd0, OP_R, 3'd0, F7_SUB, 0, 0);
        step("t5_split", 0, 1, 0);
        idle();
        step("end_idle", 0, 0, 0);
        step("end_idle", 0, 0, 0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
